decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline register between instruction fetch and the execute-side immediate generator / register file.
- Accepts fetched instruction+PC over a valid/ready handshake. Decodes the opcode into the 3-bit immediate-format code consumed by the immediate generator, plus register fields and an illegal flag.
- Registers the result behind a 2-entry skid buffer so `in_ready` is a pure flop output.

Parameters:
- `PC_W`, 32, width of program-counter path.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard all buffered instructions (branch redirect).
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  `PC_W`  PC of `in_instr`.
- `out_valid`  out  1  decoded instruction available.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  32  instruction word, forwarded to the immediate generator.
- `out_pc`  out  `PC_W`  PC.
- `out_imm_sel`  out  3  immediate format: 000 B, 001 I, 010 S, 011 U, 100 J, 111 none.
- `out_uses_imm`  out  1  1 when `out_imm_sel` != 111.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  `instr[19:15]`, `[24:20]`, `[11:7]`.
- `out_illegal`  out  1  unrecognised opcode or `instr[1:0]` != 11.
- `perf_accepted`  out  32  see Optional Feature.
- `perf_stall`  out  32  see Optional Feature.

Behaviour:
- Reset (async, `rst`=1): `main_valid`=`skid_valid`=0, `out_valid`=0, `in_ready`=1; all data outputs 0; `out_imm_sel`=111.
- Decode is combinational on `in_instr`, captured with it. Opcode `instr[6:0]` maps as follows:
  - 1100011 -> 000.
  - 0000011, 0010011, 1100111, 1110011, 0001111 -> 001.
  - 0100011 -> 010.
  - 0110111, 0010111 -> 011.
  - 1101111 -> 100.
  - 0110011 -> 111, legal.
  - Anything else -> 111, illegal.
  - `instr[1:0]` != 11 -> illegal regardless of opcode.
- Handshake transfer: in on `in_valid` & `in_ready`; out on `out_valid` & `out_ready`.
- Data must be held stable while `out_valid` & !`out_ready`.
- Storage: `main` register drives the outputs; `skid` register holds one overflow entry.
- Accept with main empty, or main popping this cycle while skid is empty: load main. Latency 1 cycle in -> `out_valid`.
- Accept while main full and not popping: load skid.
- Pop with skid full: skid -> main on the same edge; a simultaneous accept is impossible because `in_ready`=0.
- `in_ready` next = !(skid full after this edge). With downstream ready every cycle, throughput is 1 instruction/cycle.
- `flush`=1 at an edge: both valids cleared, `in_ready`=1. Any instruction offered that cycle is dropped. `flush` has priority over accept and pop.
- `out_valid` drops the cycle after flush. No partial outputs; data registers may retain stale values.
- Illegal instructions propagate as normal entries with `out_illegal`=1; no stalling.
- Reset asserted mid-transfer: outputs clear immediately (asynchronous), nothing retained.

Optional Feature:
- Macro `DECODE_PERF_CNT_EN`.
- When defined:
  - `perf_accepted` increments on each input transfer.
  - `perf_stall` increments each cycle with `out_valid` & !`out_ready`.
  - Both are 32-bit, wrap 0xFFFFFFFF -> 0, reset to 0 and are not cleared by `flush`.
- When undefined: both ports tied to 0, no counter flops.

Test Plan:
- Reset, then `in_instr`=0x00500093 (addi x1,x0,5), `out_ready`=1 -> next cycle `out_valid`=1, `out_imm_sel`=001, `rd`=1, `rs1`=0, `illegal`=0.
- Back-to-back stream of 0xFE208EE3 (beq), 0x00112023 (sw), 0x000012B7 (lui), 0x008000EF (jal), 0x002081B3 (add) with `out_ready`=1 -> `imm_sel` sequence 000, 010, 011, 100, 111, in order at one per cycle; `uses_imm` 1, 1, 1, 1, 0.
- Hold `out_ready`=0 while pushing 3 instructions -> 2 accepted, `in_ready`=0 after the second; raise `out_ready` -> both emitted in order, `in_ready` returns to 1, third accepted, no loss or duplication.
- Assert `flush` with main and skid full -> next cycle `out_valid`=0, `in_ready`=1; instruction offered during the flush cycle is never emitted.
- `in_instr`=0x0000007F and 0x00000013 with bits[1:0] forced to 00 -> `out_illegal`=1, `imm_sel`=111, both still delivered.
- With `DECODE_PERF_CNT_EN`: 4 accepts and 3 backpressured cycles -> `perf_accepted`=4, `perf_stall`=3; a flush leaves them unchanged; without the macro both read 0.

Source files
------------

// File: rtl/decode_stage.sv
// Fetch-to-execute pipeline register: opcode decode into immediate format, register fields and illegal flag,
// behind a 2-entry skid buffer with a registered in_ready. Optional perf counters under DECODE_PERF_CNT_EN.
module decode_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      out_imm_sel,
  output logic            out_uses_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic [31:0]     perf_accepted,
  output logic [31:0]     perf_stall
);

  typedef enum logic [2:0] {
    IMM_B    = 3'b000,
    IMM_I    = 3'b001,
    IMM_S    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_sel_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    imm_sel_e        imm_sel;
    logic            illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{instr: '0, pc: '0, imm_sel: IMM_NONE, illegal: 1'b0};

  entry_t in_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid, main_valid_d;
  logic   skid_valid, skid_valid_d;
  logic   in_ready_q;
  logic   accept, pop;

  // NOTE: every signal written in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    in_entry.instr   = in_instr;
    in_entry.pc      = in_pc;
    in_entry.imm_sel = IMM_NONE;
    in_entry.illegal = 1'b0;
    unique case (in_instr[6:0])
      7'b1100011:                                        in_entry.imm_sel = IMM_B;
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b1110011, 7'b0001111:                            in_entry.imm_sel = IMM_I;
      7'b0100011:                                        in_entry.imm_sel = IMM_S;
      7'b0110111, 7'b0010111:                            in_entry.imm_sel = IMM_U;
      7'b1101111:                                        in_entry.imm_sel = IMM_J;
      7'b0110011:                                        in_entry.imm_sel = IMM_NONE;
      default:                                           in_entry.illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) in_entry.illegal = 1'b1;
  end

  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = main_valid & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    if (flush) begin
      // Data registers keep stale contents; only the valids matter.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = in_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the two entry registers are small and reset fully so outputs read all-zero/none out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      in_ready_q <= ~skid_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid;
  assign out_instr    = main_q.instr;
  assign out_pc       = main_q.pc;
  assign out_imm_sel  = main_q.imm_sel;
  assign out_uses_imm = (main_q.imm_sel != IMM_NONE);
  assign out_rs1      = main_q.instr[19:15];
  assign out_rs2      = main_q.instr[24:20];
  assign out_rd       = main_q.instr[11:7];
  assign out_illegal  = main_q.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] accepted_q;
  logic [31:0] stall_q;

  // Counters survive flush; only reset clears them. Natural 32-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted_q <= '0;
      stall_q    <= '0;
    end else begin
      if (accept)                  accepted_q <= accepted_q + 32'd1;
      if (main_valid & ~out_ready) stall_q    <= stall_q + 32'd1;
    end
  end

  assign perf_accepted = accepted_q;
  assign perf_stall    = stall_q;
`else
  assign perf_accepted = '0;
  assign perf_stall    = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expected values are hand-computed per vector.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_imm_sel;
  logic        out_uses_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_illegal;
  logic [31:0] perf_accepted, perf_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_imm_sel(out_imm_sel), .out_uses_imm(out_uses_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_illegal(out_illegal),
    .perf_accepted(perf_accepted), .perf_stall(perf_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag, input int acc, input int stl);
`ifdef DECODE_PERF_CNT_EN
    check({tag, "_acc"}, perf_accepted, acc);
    check({tag, "_stall"}, perf_stall, stl);
`else
    check({tag, "_acc"}, perf_accepted, 0);
    check({tag, "_stall"}, perf_stall, 0);
`endif
  endtask

  logic [31:0] stream [5] = '{32'hFE208EE3, 32'h00112023, 32'h000012B7, 32'h008000EF, 32'h002081B3};
  logic [2:0]  stream_sel [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b111};
  logic        stream_imm [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_imm_sel", out_imm_sel, 3'b111);
    check("rst_instr", out_instr, 0);
    check("rst_uses_imm", out_uses_imm, 0);
    @(negedge clk); rst = 1'b0;
    step();

    // Single addi
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1);
    check("addi_sel", out_imm_sel, 3'b001);
    check("addi_rd", out_rd, 1);
    check("addi_rs1", out_rs1, 0);
    check("addi_illegal", out_illegal, 0);
    check("addi_pc", out_pc, 32'h100);
    step();
    check("addi_drained", out_valid, 0);

    // Back-to-back stream at full throughput
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = stream[i]; in_pc = 32'h200 + 4 * i;
      step();
      check($sformatf("stream%0d_valid", i), out_valid, 1);
      check($sformatf("stream%0d_instr", i), out_instr, stream[i]);
      check($sformatf("stream%0d_sel", i), out_imm_sel, stream_sel[i]);
      check($sformatf("stream%0d_uses", i), out_uses_imm, stream_imm[i]);
      check($sformatf("stream%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    check("add_rd", out_rd, 3);
    check("add_rs1", out_rs1, 1);
    check("add_rs2", out_rs2, 2);
    step();
    check("stream_drained", out_valid, 0);

    // Backpressure: A, B accepted, C held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A00113;
    step();
    check("bp_a_in_ready", in_ready, 1);
    in_instr = 32'h00B00193;
    step();
    check("bp_b_in_ready", in_ready, 0);
    check("bp_hold_a", out_instr, 32'h00A00113);
    in_instr = 32'h00C00213;
    step();
    step();
    check("bp_still_a", out_instr, 32'h00A00113);
    check("bp_still_full", in_ready, 0);
    check_perf("bp", 8, 3);
    out_ready = 1'b1;
    step();
    check("bp_out_b", out_instr, 32'h00B00193);
    check("bp_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_out_c", out_instr, 32'h00C00213);
    check("bp_c_valid", out_valid, 1);
    step();
    check("bp_drained", out_valid, 0);

    // Flush with main and skid full; offered instruction dropped
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00D00293;
    step();
    in_instr = 32'h00E00313;
    step();
    check("fl_full", in_ready, 0);
    flush = 1'b1; out_ready = 1'b1; in_instr = 32'h00F00393;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    step();
    check("fl_nothing_emitted", out_valid, 0);
    check_perf("fl", 11, 4);

    // Illegal encodings still delivered
    in_valid = 1'b1; in_instr = 32'h0000007F;
    step();
    check("ill1_valid", out_valid, 1);
    check("ill1_illegal", out_illegal, 1);
    check("ill1_sel", out_imm_sel, 3'b111);
    in_instr = 32'h00000010;
    step();
    in_valid = 1'b0;
    check("ill2_valid", out_valid, 1);
    check("ill2_illegal", out_illegal, 1);
    check("ill2_sel", out_imm_sel, 3'b111);
    check("ill2_instr", out_instr, 32'h00000010);
    step();
    check_perf("ill", 13, 4);

    // Asynchronous reset while holding an entry
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
    step();
    in_valid = 1'b0;
    check("ar_loaded", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_instr", out_instr, 0);
    check("ar_sel", out_imm_sel, 3'b111);
    check_perf("ar", 0, 0);
    @(negedge clk); rst = 1'b0;
    step();
    check("ar_stays_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
